// File: rtl/stream_demux1_2.sv
// Splits an alternating lane-0/lane-1 word stream into registered pairs with valid/ready on both sides.
// Optional lane-alignment checking on in_first is enabled by defining SYNC_CHECK_EN.
module stream_demux1_2 #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_0,
  output logic [WIDTH-1:0]     out_1,
  output logic [CNT_WIDTH-1:0] pair_count,
  output logic                 sync_err
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } phase_t;

  phase_t           phase;
  logic [WIDTH-1:0] hold;
  logic             accept;
  logic             drain;
  logic             lane0_load;
  logic             lane1_pair;
  logic             sync_bad;

  // Hold is separate from the output register, so lane 0 is never blocked by a stalled pair.
  always_comb begin
    drain = out_valid && out_ready;
`ifdef SYNC_CHECK_EN
    in_ready   = (phase == LANE0) || !out_valid || out_ready || in_first;
    accept     = in_valid && in_ready;
    lane0_load = accept && in_first;
    lane1_pair = accept && (phase == LANE1) && !in_first;
    sync_bad   = accept && ((phase == LANE0) ? !in_first : in_first);
`else
    in_ready   = (phase == LANE0) || !out_valid || out_ready;
    accept     = in_valid && in_ready;
    lane0_load = accept && (phase == LANE0);
    lane1_pair = accept && (phase == LANE1);
    sync_bad   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= LANE0;
      hold       <= '0;
      out_valid  <= 1'b0;
      out_0      <= '0;
      out_1      <= '0;
      pair_count <= '0;
    end else begin
      if (lane0_load) begin
        hold  <= in_data;
        phase <= LANE1;
      end else if (lane1_pair) begin
        phase <= LANE0;
      end

      // A same-edge drain and new pair keeps out_valid high with no bubble.
      if (lane1_pair) begin
        out_0     <= hold;
        out_1     <= in_data;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (drain) begin
        pair_count <= pair_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef SYNC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (sync_bad) begin
      sync_err <= 1'b1;
    end
  end
`else
  logic unused_sideband;
  assign unused_sideband = in_first ^ sync_bad;
  assign sync_err        = 1'b0;
`endif

endmodule
